ln_pair_sequencer: RTL and testbench

Sequencer that schedules one current/voltage sample pair at a time through the shared LINEALIZADOR_NORMALIZADOR datapath. It accepts an (I, V) pair on a valid/ready input port, resets the datapath, presents the operands, and pulses both Begin strobes. It then collects the two independently-timed ACK/RESULT pairs under a watchdog and returns the result pair on a valid/ready output port with an error flag. It sits between the sample source (ADC front end / FIFO) and the downstream log/power stages.

---
 rtl/ln_pair_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ln_pair_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ln_pair_sequencer.sv
// ln_pair_sequencer: runs one current/voltage sample pair at a time through
// the shared linearizer/normalizer datapath. It resets the datapath, presents
// the operands, pulses both start strobes, collects the two ACK/RESULT pairs
// under a watchdog, and offers the result pair downstream with an error flag.
module ln_pair_sequencer #(
  parameter int unsigned P       = 32,
  parameter int unsigned TIMEOUT = 2500,
  parameter int unsigned TW      = 12
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [P-1:0] I_IN,
  input  logic [P-1:0] V_IN,
  output logic         DP_RST,
  output logic [P-1:0] DP_I,
  output logic [P-1:0] DP_V,
  output logic         BEGIN_FSM_I,
  output logic         BEGIN_FSM_V,
  input  logic         ACK_I,
  input  logic         ACK_V,
  input  logic [31:0]  RESULT_I,
  input  logic [31:0]  RESULT_V,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [31:0]  OUT_I,
  output logic [31:0]  OUT_V,
  output logic         OUT_ERR,
  output logic [7:0]   ERR_CNT
);

  // Watchdog counter must be able to reach TIMEOUT-1.
  if ((TIMEOUT < 1) || ((64'd1 << TW) <= 64'(TIMEOUT))) begin : g_param_check
    $error("ln_pair_sequencer: TIMEOUT must be >= 1 and 2**TW > TIMEOUT");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [P-1:0]  dp_i_q, dp_i_d;
  logic [P-1:0]  dp_v_q, dp_v_d;
  logic [31:0]   out_i_q, out_i_d;
  logic [31:0]   out_v_q, out_v_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          ack_i_q, ack_i_d;
  logic          ack_v_q, ack_v_d;
  logic [TW-1:0] wd_q, wd_d;

  // Strobes and handshakes are registered copies decoded from the next state,
  // so every output changes only on a clock edge.
  logic          in_ready_q;
  logic          dp_rst_q;
  logic          begin_q;
  logic          out_valid_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    dp_i_d    = dp_i_q;
    dp_v_d    = dp_v_q;
    out_i_d   = out_i_q;
    out_v_d   = out_v_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    ack_i_d   = ack_i_q;
    ack_v_d   = ack_v_q;
    wd_d      = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (IN_VALID && in_ready_q) begin
          dp_i_d  = I_IN;
          dp_v_d  = V_IN;
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: state_d = ST_LOAD;

      ST_LOAD: state_d = ST_START;

      ST_START: begin
        // Clearing the result registers here makes a missing channel read 0
        // if the watchdog fires.
        ack_i_d = 1'b0;
        ack_v_d = 1'b0;
        wd_d    = '0;
        out_i_d = '0;
        out_v_d = '0;
        err_d   = 1'b0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (ACK_I && !ack_i_q) begin
          ack_i_d = 1'b1;
          out_i_d = RESULT_I;
        end
        if (ACK_V && !ack_v_q) begin
          ack_v_d = 1'b1;
          out_v_d = RESULT_V;
        end
        // Completion is tested before the watchdog so a final ACK arriving in
        // the timeout cycle still counts as success.
        if (ack_i_d && ack_v_d) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end

      ST_DONE: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered-output flops; reset holds the datapath in reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      dp_i_q      <= '0;
      dp_v_q      <= '0;
      out_i_q     <= '0;
      out_v_q     <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      ack_i_q     <= 1'b0;
      ack_v_q     <= 1'b0;
      wd_q        <= '0;
      in_ready_q  <= 1'b0;
      dp_rst_q    <= 1'b1;
      begin_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dp_i_q      <= dp_i_d;
      dp_v_q      <= dp_v_d;
      out_i_q     <= out_i_d;
      out_v_q     <= out_v_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      ack_i_q     <= ack_i_d;
      ack_v_q     <= ack_v_d;
      wd_q        <= wd_d;
      in_ready_q  <= (state_d == ST_IDLE);
      dp_rst_q    <= (state_d == ST_CLEAR);
      begin_q     <= (state_d == ST_START);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign IN_READY    = in_ready_q;
  assign DP_RST      = dp_rst_q;
  assign DP_I        = dp_i_q;
  assign DP_V        = dp_v_q;
  assign BEGIN_FSM_I = begin_q;
  assign BEGIN_FSM_V = begin_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_I       = out_i_q;
  assign OUT_V       = out_v_q;
  assign OUT_ERR     = err_q;
  assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_ln_pair_sequencer.sv
// Directed self-checking bench for ln_pair_sequencer with a behavioural
// datapath model that raises ACKs a configurable number of cycles after BEGIN.
module tb_ln_pair_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] I_IN, V_IN;
  logic        DP_RST;
  logic [31:0] DP_I, DP_V;
  logic        BEGIN_FSM_I, BEGIN_FSM_V;
  logic        ACK_I, ACK_V;
  logic [31:0] RESULT_I, RESULT_V;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_I, OUT_V;
  logic        OUT_ERR;
  logic [7:0]  ERR_CNT;

  int total = 0;
  int bad   = 0;

  // Datapath model configuration (written by the stimulus block).
  logic [7:0]  lat_i, lat_v;        // 0 = channel never acknowledges
  logic [31:0] cfg_res_i, cfg_res_v;
  logic        golden_en;
  logic        ovr_en;
  logic [31:0] ovr_val;

  logic [7:0]  cnt_i, cnt_v;
  logic        act_i, act_v;
  logic [31:0] res_i_q, res_v_q;

  ln_pair_sequencer #(.P(32), .TIMEOUT(100), .TW(12)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .I_IN(I_IN), .V_IN(V_IN),
    .DP_RST(DP_RST), .DP_I(DP_I), .DP_V(DP_V),
    .BEGIN_FSM_I(BEGIN_FSM_I), .BEGIN_FSM_V(BEGIN_FSM_V),
    .ACK_I(ACK_I), .ACK_V(ACK_V), .RESULT_I(RESULT_I), .RESULT_V(RESULT_V),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_I(OUT_I), .OUT_V(OUT_V), .OUT_ERR(OUT_ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] gold_i(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] gold_v(input logic [31:0] x);
    return x + 32'h12345678;
  endfunction

  function automatic logic [31:0] stim_i(input int n);
    return 32'h3F800000 ^ (32'(n) * 32'h9E3779B1);
  endfunction

  function automatic logic [31:0] stim_v(input int n);
    return ~stim_i(n) + 32'(n);
  endfunction

  // Datapath model: ACK is a level held until DP_RST.
  always @(posedge CLK) begin
    if (DP_RST) begin
      ACK_I <= 1'b0; ACK_V <= 1'b0; act_i <= 1'b0; act_v <= 1'b0;
      cnt_i <= '0; cnt_v <= '0; res_i_q <= '0; res_v_q <= '0;
    end else begin
      if (BEGIN_FSM_I) begin
        cnt_i <= golden_en ? (8'd1 + {5'd0, DP_I[2:0]}) : lat_i;
        act_i <= golden_en || (lat_i != 8'd0);
      end else if (act_i) begin
        cnt_i <= cnt_i - 8'd1;
        if (cnt_i == 8'd1) begin
          ACK_I   <= 1'b1;
          res_i_q <= golden_en ? gold_i(DP_I) : cfg_res_i;
          act_i   <= 1'b0;
        end
      end
      if (BEGIN_FSM_V) begin
        cnt_v <= golden_en ? (8'd1 + {5'd0, DP_V[3:1]}) : lat_v;
        act_v <= golden_en || (lat_v != 8'd0);
      end else if (act_v) begin
        cnt_v <= cnt_v - 8'd1;
        if (cnt_v == 8'd1) begin
          ACK_V   <= 1'b1;
          res_v_q <= golden_en ? gold_v(DP_V) : cfg_res_v;
          act_v   <= 1'b0;
        end
      end
    end
  end

  assign RESULT_I = ovr_en ? ovr_val : res_i_q;
  assign RESULT_V = res_v_q;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accepts one pair and walks CLEAR/LOAD/START; returns in the first WAIT cycle.
  task automatic start_job(input logic [31:0] i, input logic [31:0] v);
    IN_VALID = 1'b1; I_IN = i; V_IN = v;
    for (int n = 0; n < 300 && !IN_READY; n++) tick();
    chk("in_ready_before_accept", IN_READY, 1);
    tick();
    IN_VALID = 1'b0;
    chk("clear_dp_rst", DP_RST, 1);
    chk("clear_begin", BEGIN_FSM_I, 0);
    chk("clear_in_ready", IN_READY, 0);
    chk("clear_dp_i", DP_I, i);
    tick();
    chk("load_dp_rst", DP_RST, 0);
    chk("load_begin", {BEGIN_FSM_I, BEGIN_FSM_V}, 0);
    chk("load_dp_v", DP_V, v);
    tick();
    chk("start_begin", {BEGIN_FSM_I, BEGIN_FSM_V}, 2'b11);
    chk("start_dp_rst", DP_RST, 0);
    tick();
    chk("wait_begin", {BEGIN_FSM_I, BEGIN_FSM_V}, 0);
  endtask

  task automatic run_nominal(input string tag);
    lat_i = 8'd40; lat_v = 8'd55;
    cfg_res_i = 32'h3F000000; cfg_res_v = 32'h3E800000;
    start_job(32'h3F800000, 32'h40000000);
    for (int n = 0; n < 200 && !ACK_V; n++) tick();
    chk({tag, "_ackv_seen"}, ACK_V, 1);
    chk({tag, "_no_valid_at_ack"}, OUT_VALID, 0);
    tick();
    chk({tag, "_valid"}, OUT_VALID, 1);
    chk({tag, "_out_i"}, OUT_I, 32'h3F000000);
    chk({tag, "_out_v"}, OUT_V, 32'h3E800000);
    chk({tag, "_err"}, OUT_ERR, 0);
    chk({tag, "_in_ready_done"}, IN_READY, 0);
    tick();
    chk({tag, "_in_ready_back"}, IN_READY, 1);
    chk({tag, "_valid_drop"}, OUT_VALID, 0);
  endtask

  initial begin
    int in_idx, out_idx, cyc;
    logic acc;
    RST_N = 1'b1; IN_VALID = 1'b0; I_IN = '0; V_IN = '0; OUT_READY = 1'b1;
    lat_i = '0; lat_v = '0; cfg_res_i = '0; cfg_res_v = '0;
    golden_en = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    #1 RST_N = 1'b0;
    #2;
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_dp_rst", DP_RST, 1);
    chk("rst_dp_i", DP_I, 0);
    chk("rst_dp_v", DP_V, 0);
    chk("rst_begin", {BEGIN_FSM_I, BEGIN_FSM_V}, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_i", OUT_I, 0);
    chk("rst_out_v", OUT_V, 0);
    chk("rst_out_err", OUT_ERR, 0);
    chk("rst_err_cnt", ERR_CNT, 0);
    tick(); tick();
    chk("rst_held_dp_rst", DP_RST, 1);
    RST_N = 1'b1;
    tick();
    chk("rel_dp_rst", DP_RST, 0);
    chk("rel_in_ready", IN_READY, 1);

    // Nominal pair
    run_nominal("nom");

    // Simultaneous ACKs, late RESULT change, and 50 cycles of backpressure
    lat_i = 8'd20; lat_v = 8'd20;
    cfg_res_i = 32'h11111111; cfg_res_v = 32'h22222222;
    OUT_READY = 1'b0;
    start_job(32'h01234567, 32'h89ABCDEF);
    for (int n = 0; n < 100 && !ACK_I; n++) tick();
    chk("sim_acki_seen", ACK_I, 1);
    chk("sim_ackv_same", ACK_V, 1);
    tick();
    ovr_en = 1'b1; ovr_val = 32'hDEADBEEF;
    for (int n = 0; n < 50; n++) begin
      chk("bp_valid", OUT_VALID, 1);
      chk("bp_out_i", OUT_I, 32'h11111111);
      chk("bp_out_v", OUT_V, 32'h22222222);
      chk("bp_err", OUT_ERR, 0);
      chk("bp_in_ready", IN_READY, 0);
      tick();
    end
    OUT_READY = 1'b1;
    chk("bp_last_valid", OUT_VALID, 1);
    tick();
    ovr_en = 1'b0;
    chk("bp_in_ready_back", IN_READY, 1);
    chk("bp_valid_drop", OUT_VALID, 0);

    // Watchdog timeout with only the I channel answering
    lat_i = 8'd10; lat_v = 8'd0; cfg_res_i = 32'h33333333;
    start_job(32'h0BADF00D, 32'h0000FACE);
    repeat (99) tick();
    chk("to_not_yet", OUT_VALID, 0);
    tick();
    chk("to_valid", OUT_VALID, 1);
    chk("to_err", OUT_ERR, 1);
    chk("to_out_i", OUT_I, 32'h33333333);
    chk("to_out_v", OUT_V, 0);
    chk("to_err_cnt", ERR_CNT, 1);
    tick();
    for (int k = 0; k < 299; k++) begin
      start_job(32'(k), 32'(k) + 32'h100);
      for (int n = 0; n < 200 && !OUT_VALID; n++) tick();
      chk("abort_err", OUT_ERR, 1);
      tick();
    end
    chk("err_cnt_sat", ERR_CNT, 8'd255);

    // Reset ten cycles into WAIT
    lat_i = 8'd50; lat_v = 8'd50;
    start_job(32'h55555555, 32'h66666666);
    repeat (10) tick();
    RST_N = 1'b0;
    #1;
    chk("mid_rst_dp_rst", DP_RST, 1);
    chk("mid_rst_err_cnt", ERR_CNT, 0);
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_in_ready", IN_READY, 0);
    chk("mid_rst_dp_i", DP_I, 0);
    chk("mid_rst_out_i", OUT_I, 0);
    tick(); tick();
    chk("mid_rst_dp_rst_held", DP_RST, 1);
    RST_N = 1'b1;
    tick();
    chk("mid_rel_dp_rst", DP_RST, 0);
    chk("mid_rel_in_ready", IN_READY, 1);
    chk("mid_rel_valid", OUT_VALID, 0);
    run_nominal("post_rst");

    // Back-to-back stream against the golden datapath model
    golden_en = 1'b1; OUT_READY = 1'b1;
    in_idx = 0; out_idx = 0;
    I_IN = stim_i(0); V_IN = stim_v(0); IN_VALID = 1'b1;
    for (cyc = 0; cyc < 40000 && out_idx < 1024; cyc++) begin
      acc = IN_READY && IN_VALID;
      if (OUT_VALID) begin
        chk("stream_out_i", OUT_I, gold_i(stim_i(out_idx)));
        chk("stream_out_v", OUT_V, gold_v(stim_v(out_idx)));
        chk("stream_err", OUT_ERR, 0);
        out_idx++;
      end
      tick();
      if (acc) begin
        in_idx++;
        if (in_idx < 1024) begin
          I_IN = stim_i(in_idx); V_IN = stim_v(in_idx);
        end else begin
          IN_VALID = 1'b0;
        end
      end
    end
    chk("stream_count", 32'(out_idx), 32'd1024);
    chk("stream_err_cnt", ERR_CNT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
